otter_iobus_uart_tx: RTL and testbench

- Memory-mapped IOBUS responder on the OTTER processor's IOBUS. The CPU drives IOBUS_ADDR, IOBUS_OUT and IOBUS_WR; this block returns read data on IOBUS_IN.
- Bytes written by the CPU are buffered in a FIFO and serialized as 8N1 UART frames on UART_TXD.
- Status is readable so firmware can poll before writing.
- Sits beside the IOBUS input mux in the top-level wrapper.

---
 rtl/otter_iobus_uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_otter_iobus_uart_tx.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_iobus_uart_tx.sv
// IOBUS-mapped UART transmitter: TXDATA/STATUS/CTRL register window, byte FIFO, 8N1 serializer.
module otter_iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        UART_TXD,
  output logic        TX_IRQ
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Reset: asserts asynchronously, deasserts two clocks after RST_N rises
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              tx_en_q, tx_en_d, irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  logic [31:0] word_addr;
  logic        sel_data, sel_status, sel_ctrl;
  logic        wr_data, wr_status, wr_ctrl;
  logic        full, empty, busy, baud_end;
  logic        push, pop, drop;
  logic        unused_bits;

  // Address decode: low two bits ignored, the rest compared in full
  assign word_addr  = {IOBUS_ADDR[31:2], 2'b00};
  assign sel_data   = (word_addr == BASE_ADDR);
  assign sel_status = (word_addr == BASE_ADDR + 32'd4);
  assign sel_ctrl   = (word_addr == BASE_ADDR + 32'd8);
  assign wr_data    = IOBUS_WR & sel_data;
  assign wr_status  = IOBUS_WR & sel_status;
  assign wr_ctrl    = IOBUS_WR & sel_ctrl;

  assign full     = (count_q == CntFull);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  assign baud_end = (baud_q == BaudMax);

  assign unused_bits = ^{IOBUS_OUT[31:8], IOBUS_ADDR[1:0]};

  // Serializer next state; TXD is registered from the next state so it changes with the FSM
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the serializer pops on the same edge
  always_comb begin
    push     = wr_data && (!full || pop);
    drop     = wr_data && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (drop)                          ovf_d = 1'b1;
    else if (wr_status && IOBUS_OUT[3]) ovf_d = 1'b0;
  end

  // Control register and interrupt next state
  always_comb begin
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    if (wr_ctrl) begin
      tx_en_d  = IOBUS_OUT[0];
      irq_en_d = IOBUS_OUT[1];
    end
    irq_d = empty & irq_en_q;
  end

  // State registers
  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
  end

  // Read mux
  always_comb begin
    IOBUS_IN = '0;
    if (sel_status) IOBUS_IN = {16'h0, 8'(count_q), 4'h0, ovf_q, full, empty, busy};
    else if (sel_ctrl) IOBUS_IN = {30'h0, irq_en_q, tx_en_q};
  end

  assign UART_TXD = txd_q;
  assign TX_IRQ   = irq_q;

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Self-checking bench for otter_iobus_uart_tx (4 clocks per bit, 4-entry FIFO).
module tb_otter_iobus_uart_tx;

  localparam logic [31:0] Base       = 32'h1100_0100;
  localparam logic [31:0] AddrData   = Base;
  localparam logic [31:0] AddrStatus = Base + 32'd4;
  localparam logic [31:0] AddrCtrl   = Base + 32'd8;
  localparam int          Depth      = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        UART_TXD;
  logic        TX_IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents and sticky overflow
  logic [7:0] model_q[$];
  bit         model_ovf = 1'b0;

  otter_iobus_uart_tx #(
    .BASE_ADDR   (Base),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .UART_TXD  (UART_TXD),
    .TX_IRQ    (TX_IRQ)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200us;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    #1;
    d = IOBUS_IN;
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() < Depth) model_q.push_back(b);
    else model_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] model_status(input int cnt, input bit ovf, input bit bsy);
    logic [7:0] c8;
    c8 = 8'(cnt);
    return {16'h0, c8, 4'h0, ovf, (cnt == Depth), (cnt == 0), bsy};
  endfunction

  // Expected TXD per cycle of a frame: start, 8 data bits LSB first, stop; 4 cycles each
  function automatic logic [39:0] expand_frame(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] v;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) v[k] = f[k/4];
    return v;
  endfunction

  // Records 40 cycles of TXD and whether STATUS.busy stayed set
  task automatic capture_frame(input bit skip_first, output logic [39:0] bits,
                               output logic busy_all);
    logic [31:0] st;
    busy_all = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!(skip_first && k == 0)) tick();
      bits[k] = UART_TXD;
      bus_read(AddrStatus, st);
      busy_all &= st[0];
    end
  endtask

  // Transmits every queued model byte, first frame starting at the next edge
  task automatic drain_queue(input string tag);
    logic [39:0] bits, exp;
    logic        bsy;
    logic [7:0]  b;
    while (model_q.size() > 0) begin
      b = model_q.pop_front();
      capture_frame(1'b0, bits, bsy);
      exp = expand_frame(b);
      n_checks++;
      if (bits !== exp) begin
        n_fail++;
        $display("FAIL %s frame %02h: txd %h expected %h", tag, b, bits, exp);
      end
      n_checks++;
      if (bsy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy during frame %02h: got %b expected 1", tag, b, bsy);
      end
      tick();
      n_checks++;
      if (UART_TXD !== 1'b1) begin
        n_fail++;
        $display("FAIL %s idle gap txd: got %b expected 1", tag, UART_TXD);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (UART_TXD !== 1'b1) begin
      n_fail++; $display("FAIL reset txd: got %b expected 1", UART_TXD);
    end
    n_checks++;
    if (TX_IRQ !== 1'b0) begin
      n_fail++; $display("FAIL reset irq: got %b expected 0", TX_IRQ);
    end
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(0, 0, 0)) begin
      n_fail++; $display("FAIL reset status: got %h expected %h", d, model_status(0, 0, 0));
    end
    bus_read(AddrCtrl, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL reset ctrl: got %h expected 00000001", d);
    end
    bus_read(AddrData, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL reset txdata read: got %h expected 00000000", d);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0]  b;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? 8'hA5 : 8'($urandom);
      bus_write(AddrData, {$urandom_range(0, 32'hFF_FFFF), b} & 32'hFFFF_FFFF);
      model_push(b);
      drain_queue("single");
      bus_read(AddrStatus, d);
      n_checks++;
      if (d !== model_status(0, model_ovf, 0)) begin
        n_fail++; $display("FAIL single status after frame: got %h expected %h", d,
                           model_status(0, model_ovf, 0));
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bus_write(AddrCtrl, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      bus_write(AddrData, 32'(i));
      model_push(8'(i));
    end
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(model_q.size(), model_ovf, 0)) begin
      n_fail++; $display("FAIL overflow status: got %h expected %h", d,
                         model_status(model_q.size(), model_ovf, 0));
    end
    bus_write(AddrCtrl, 32'h1);
    drain_queue("overflow");
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(0, model_ovf, 0)) begin
      n_fail++; $display("FAIL overflow status after drain: got %h expected %h", d,
                         model_status(0, model_ovf, 0));
    end
    bus_write(AddrStatus, 32'h8);
    model_ovf = 1'b0;
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(0, model_ovf, 0)) begin
      n_fail++; $display("FAIL overflow clear: got %h expected %h", d, model_status(0, 0, 0));
    end
  endtask

  task automatic test_push_on_pop();
    logic [7:0]  x, first;
    logic [31:0] d;
    logic [39:0] bits, exp;
    logic        bsy;
    bus_write(AddrCtrl, 32'h0);
    for (int i = 0; i < Depth; i++) begin
      x = 8'($urandom);
      bus_write(AddrData, {24'h0, x});
      model_push(x);
    end
    bus_write(AddrCtrl, 32'h1);
    // This push lands on the pop edge of the first frame
    x = 8'($urandom);
    bus_write(AddrData, {24'h0, x});
    first = model_q.pop_front();
    model_push(x);
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(model_q.size(), model_ovf, 1)) begin
      n_fail++; $display("FAIL push_on_pop status: got %h expected %h", d,
                         model_status(model_q.size(), model_ovf, 1));
    end
    capture_frame(1'b1, bits, bsy);
    exp = expand_frame(first);
    n_checks++;
    if (bits !== exp) begin
      n_fail++; $display("FAIL push_on_pop first frame: txd %h expected %h", bits, exp);
    end
    tick();
    drain_queue("push_on_pop");
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(0, model_ovf, 0)) begin
      n_fail++; $display("FAIL push_on_pop final status: got %h expected %h", d,
                         model_status(0, model_ovf, 0));
    end
  endtask

  task automatic test_random_burst();
    int          n;
    logic [7:0]  b, first;
    logic [31:0] d;
    logic [39:0] bits, exp;
    logic        bsy, idle_all;
    bus_write(AddrCtrl, 32'h0);
    n = int'($urandom_range(2, 7));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      bus_write(AddrData, {24'h0, b});
      model_push(b);
    end
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(model_q.size(), model_ovf, 0)) begin
      n_fail++; $display("FAIL burst status n=%0d: got %h expected %h", n, d,
                         model_status(model_q.size(), model_ovf, 0));
    end
    // Enable for one edge only: the frame started must finish, then the rest waits
    bus_write(AddrCtrl, 32'h1);
    bus_write(AddrCtrl, 32'h0);
    first = model_q.pop_front();
    capture_frame(1'b1, bits, bsy);
    exp = expand_frame(first);
    n_checks++;
    if (bits !== exp) begin
      n_fail++; $display("FAIL burst frame after tx_en off: txd %h expected %h", bits, exp);
    end
    idle_all = 1'b1;
    for (int k = 0; k < 21; k++) begin
      tick();
      idle_all &= UART_TXD;
    end
    n_checks++;
    if (idle_all !== 1'b1) begin
      n_fail++; $display("FAIL burst hold with tx_en=0: txd idle %b expected 1", idle_all);
    end
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(model_q.size(), model_ovf, 0)) begin
      n_fail++; $display("FAIL burst retained fifo: got %h expected %h", d,
                         model_status(model_q.size(), model_ovf, 0));
    end
    bus_write(AddrCtrl, 32'h1);
    drain_queue("burst");
    bus_write(AddrStatus, 32'h8);
    model_ovf = 1'b0;
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(0, 0, 0)) begin
      n_fail++; $display("FAIL burst final status: got %h expected %h", d, model_status(0, 0, 0));
    end
  endtask

  task automatic test_irq_and_decode();
    logic [31:0] d;
    bus_write(AddrCtrl, 32'h3);
    n_checks++;
    if (TX_IRQ !== 1'b0) begin
      n_fail++; $display("FAIL irq same edge as enable: got %b expected 0", TX_IRQ);
    end
    tick();
    n_checks++;
    if (TX_IRQ !== 1'b1) begin
      n_fail++; $display("FAIL irq after enable: got %b expected 1", TX_IRQ);
    end
    bus_write(AddrData, {24'h0, 8'($urandom)});
    tick();
    n_checks++;
    if (TX_IRQ !== 1'b0) begin
      n_fail++; $display("FAIL irq after push: got %b expected 0", TX_IRQ);
    end
    tick();
    n_checks++;
    if (TX_IRQ !== 1'b1) begin
      n_fail++; $display("FAIL irq after pop emptied fifo: got %b expected 1", TX_IRQ);
    end
    bus_read(32'h1100_0110, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL read outside window: got %h expected 00000000", d);
    end
    bus_write(32'h1100_010C, 32'h0);
    bus_read(Base + 32'd9, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++; $display("FAIL ctrl after stray write (aliased read): got %h expected 00000003", d);
    end
    repeat (45) tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  b;
    logic [31:0] d;
    logic        idle_all;
    b = 8'($urandom) & 8'hF7;
    bus_write(AddrData, {24'h0, b});
    repeat (17) tick();
    n_checks++;
    if (UART_TXD !== 1'b0) begin
      n_fail++; $display("FAIL data bit3 before reset: got %b expected 0", UART_TXD);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (UART_TXD !== 1'b1) begin
      n_fail++; $display("FAIL txd on async reset: got %b expected 1", UART_TXD);
    end
    n_checks++;
    if (TX_IRQ !== 1'b0) begin
      n_fail++; $display("FAIL irq on async reset: got %b expected 0", TX_IRQ);
    end
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (3) tick();
    bus_read(AddrStatus, d);
    n_checks++;
    if (d !== model_status(0, 0, 0)) begin
      n_fail++; $display("FAIL status after reset: got %h expected %h", d, model_status(0, 0, 0));
    end
    bus_read(AddrCtrl, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL ctrl after reset: got %h expected 00000001", d);
    end
    idle_all = 1'b1;
    for (int k = 0; k < 45; k++) begin
      tick();
      idle_all &= UART_TXD;
    end
    n_checks++;
    if (idle_all !== 1'b1) begin
      n_fail++; $display("FAIL residual bits after reset: txd idle %b expected 1", idle_all);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_push_on_pop();
    test_random_burst();
    test_irq_and_decode();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
